// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter in front of the shared 32-bit barrel shifter,
// with a one-entry valid/ready result register toward the consumer.
module shift_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_d,
    input  logic [4:0]       req0_sa,
    input  logic             req0_right,
    input  logic             req0_arith,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_d,
    input  logic [4:0]       req1_sa,
    input  logic             req1_right,
    input  logic             req1_arith,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sh,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    logic             last_grant;
    logic             accept;
    logic             grant0;
    logic             grant1;
    logic             xfer;
    logic             sel;

    logic [31:0]      sel_d;
    logic [4:0]       sel_sa;
    logic             sel_right;
    logic             sel_arith;
    logic [TAG_W-1:0] sel_tag;

    logic             fill;
    logic [31:0]      st0;
    logic [31:0]      st1;
    logic [31:0]      st2;
    logic [31:0]      st3;
    logic [31:0]      st4;
    logic [31:0]      st5;
    logic [31:0]      shifted;

    // Round-robin: on contention the requester not granted most recently wins.
    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        accept     = ~out_valid | out_ready;
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = ~rst & accept & grant0;
        req1_ready = ~rst & accept & grant1;
    end

    assign xfer = req0_ready | req1_ready;
    assign sel  = req1_ready;

    always_comb begin
        if (sel) begin
            sel_d     = req1_d;
            sel_sa    = req1_sa;
            sel_right = req1_right;
            sel_arith = req1_arith;
            sel_tag   = req1_tag;
        end else begin
            sel_d     = req0_d;
            sel_sa    = req0_sa;
            sel_right = req0_right;
            sel_arith = req0_arith;
            sel_tag   = req0_tag;
        end
    end

    // A single right-shifting log stage network; left shifts reverse the bits on the way in and out.
    always_comb begin
        fill    = sel_right & sel_arith & sel_d[31];
        st0     = sel_right ? sel_d : bit_reverse(sel_d);
        st1     = sel_sa[0] ? {fill, st0[31:1]}         : st0;
        st2     = sel_sa[1] ? {{2{fill}}, st1[31:2]}    : st1;
        st3     = sel_sa[2] ? {{4{fill}}, st2[31:4]}    : st2;
        st4     = sel_sa[3] ? {{8{fill}}, st3[31:8]}    : st3;
        st5     = sel_sa[4] ? {{16{fill}}, st4[31:16]}  : st4;
        shifted = sel_right ? st5 : bit_reverse(st5);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sh     <= '0;
            out_src    <= 1'b0;
            out_tag    <= '0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_sh     <= shifted;
            out_src    <= sel;
            out_tag    <= sel_tag;
            last_grant <= sel;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arb.sv
// Directed bench for shift_arb: expected results are queued by the stimulus and
// popped by an independent monitor whenever the consumer takes a result.
module tb_shift_arb;

    typedef struct packed {
        logic [31:0] sh;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_right, req0_arith;
    logic [31:0] req0_d;
    logic [4:0]  req0_sa;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_right, req1_arith;
    logic [31:0] req1_d;
    logic [4:0]  req1_sa;
    logic [3:0]  req1_tag;
    logic        out_valid, out_ready, out_src;
    logic [31:0] out_sh;
    logic [3:0]  out_tag;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    shift_arb #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_d(req0_d), .req0_sa(req0_sa),
        .req0_right(req0_right), .req0_arith(req0_arith), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_d(req1_d), .req1_sa(req1_sa),
        .req1_right(req1_right), .req1_arith(req1_arith), .req1_tag(req1_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh),
        .out_src(out_src), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] sh, input logic src, input logic [3:0] tag);
        exp_t e;
        e.sh  = sh;
        e.src = src;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic n, input logic [31:0] d, input logic [4:0] sa,
                           input logic right, input logic arith, input logic [3:0] tag);
        if (n) begin
            req1_d = d; req1_sa = sa; req1_right = right; req1_arith = arith; req1_tag = tag;
            req1_valid = 1'b1;
        end else begin
            req0_d = d; req0_sa = sa; req0_right = right; req0_arith = arith; req0_tag = tag;
            req0_valid = 1'b1;
        end
    endtask

    // Present one operation, wait (bounded) for its ready, complete the transfer, drop valid.
    task automatic issue(input logic n, input logic [31:0] d, input logic [4:0] sa,
                         input logic right, input logic arith, input logic [3:0] tag);
        int waited = 0;
        set_req(n, d, sa, right, arith, tag);
        #1;
        while (!(n ? req1_ready : req0_ready) && waited < 20) begin
            tick();
            waited++;
        end
        check("issue_ready", {31'd0, (n ? req1_ready : req0_ready)}, 32'd1);
        tick();
        if (n) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    // Monitor: every accepted result is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_sh", out_sh, e.sh);
                check("out_src", {31'd0, out_src}, {31'd0, e.src});
                check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0;
        req0_valid = 0; req0_d = 0; req0_sa = 0; req0_right = 0; req0_arith = 0; req0_tag = 0;
        req1_valid = 0; req1_d = 0; req1_sa = 0; req1_right = 0; req1_arith = 0; req1_tag = 0;
        repeat (2) tick();

        // Reset state; readies stay low under reset even with both valids high.
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_out_sh",     out_sh,              32'd0);
        check("rst_out_src",    {31'd0, out_src},    32'd0);
        check("rst_out_tag",    {28'd0, out_tag},    32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Arithmetic right on req0.
        push(32'hF800_0000, 1'b0, 4'd3);
        issue(1'b0, 32'h8000_0001, 5'd4, 1'b1, 1'b1, 4'd3);
        check("arith_out_valid", {31'd0, out_valid}, 32'd1);

        // Single requester, two back-to-back operations.
        push(32'h0000_FF00, 1'b1, 4'd5);
        issue(1'b1, 32'h0000_00FF, 5'd8, 1'b0, 1'b0, 4'd5);
        push(32'h0000_0001, 1'b1, 4'd6);
        issue(1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 4'd6);
        tick();

        // Contention from reset: grants alternate 0,1,0,1 at full throughput.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 4'd1);
        set_req(1'b1, 32'h0000_0010, 5'd4, 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(32'h0000_0002, 1'b0, 4'd1);
            else            push(32'h0000_0001, 1'b1, 4'd2);
        end
        #1;
        check("cont_first_ready0", {30'd0, req1_ready, req0_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cont_out_valid", {31'd0, out_valid}, 32'd1);
            check("cont_out_src", {31'd0, out_src}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure: req0 served first (req1 was last), held 5 cycles, then req1.
        out_ready = 1'b0;
        set_req(1'b0, 32'h0000_000F, 5'd2, 1'b0, 1'b0, 4'd7);
        set_req(1'b1, 32'hF000_0000, 5'd4, 1'b1, 1'b1, 4'd8);
        push(32'h0000_003C, 1'b0, 4'd7);
        #1;
        check("bp_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_sh", out_sh, 32'h0000_003C);
            check("bp_hold_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        push(32'hFF00_0000, 1'b1, 4'd8);
        #1;
        check("bp_release_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("bp_reload_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // sa=0 passes the operand unchanged for every direction/arith combination.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] c;
            c = 2'(i);
            push(32'h1234_5678, 1'b0, {2'b00, c});
            issue(1'b0, 32'h1234_5678, 5'd0, c[1], c[0], {2'b00, c});
        end
        tick();

        // Reset while a result is held: it is discarded and nothing transfers on the reset edge.
        out_ready = 1'b0;
        issue(1'b0, 32'hA5A5_A5A5, 5'd1, 1'b0, 1'b0, 4'd9);
        check("mid_held_valid", {31'd0, out_valid}, 32'd1);
        check("mid_held_sh", out_sh, 32'h4B4B_4B4A);
        set_req(1'b0, 32'h0000_0003, 5'd30, 1'b0, 1'b0, 4'd4);
        set_req(1'b1, 32'h0000_0100, 5'd8, 1'b1, 1'b0, 4'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        check("mid_post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_post_rst_sh", out_sh, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'hC000_0000, 1'b0, 4'd4);
        #1;
        check("mid_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_arb.md
# shift_arb

Two-requester arbiter and result register for the 32-bit barrel shifter in the execute datapath. It accepts shift operations from two independent requesters over valid/ready handshakes and grants the shifter round-robin when both compete. It drives the shared combinational shifter with the granted operands and captures the result in a one-entry output register, with valid/ready backpressure toward the consumer.

## Interface
Parameters:
- TAG_W, default 4: width of the opaque tag carried with each request and returned with its result.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_d  in  32  requester 0 operand.
- req0_sa  in  5  requester 0 shift amount.
- req0_right  in  1  requester 0: 0 = left, 1 = right.
- req0_arith  in  1  requester 0: arithmetic when right=1; ignored when right=0.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid, req1_ready, req1_d, req1_sa, req1_right, req1_arith, req1_tag: same as requester 0, for requester 1.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_sh  out  32  shift result.
- out_src  out  1  requester index that produced out_sh.
- out_tag  out  TAG_W  tag of that request.

## Operation
- Shift function:
  - right=0: logical left, d << sa.
  - right=1, arith=0: logical right.
  - right=1, arith=1: arithmetic right, sign bit replicated.
  - sa range is 0..31; sa=0 passes d unchanged.
- accept = ~out_valid | out_ready.
- Grant:
  - Only one valid requester: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- reqN_ready = accept & grantN. It is combinational and may depend on reqN_valid and out_ready.
  - At most one ready is high in any cycle.
  - A ready is never high without its valid.
- Transfer when reqN_valid & reqN_ready. On the next edge:
  - out_sh ← shift(reqN operands); out_src ← N; out_tag ← reqN_tag; out_valid ← 1.
  - last_grant ← N.
- Output handshake and hold:
  - out_valid & out_ready with no new transfer: out_valid ← 0; out_sh, out_src and out_tag hold their values.
  - Drain and a new transfer in the same cycle: the register is reloaded and out_valid stays 1. This gives full throughput.
  - out_valid=1 & out_ready=0: out_sh, out_src and out_tag are held stable and both readies are 0.
- Requesters must hold operands and valid stable until ready. The arbiter samples operands only in the transfer cycle.
- last_grant changes only on a transfer, never on contention alone.
- Internal state: output register (out_valid, out_sh, out_src, out_tag) and last_grant. No other state.

## Timing
- Latency: 1 cycle. A result transferred at edge k is visible on out_* after edge k.
- Throughput: 1 operation per cycle when out_ready=1.
- Reset (rst=1 at an edge) sets: out_valid=0, out_sh=0, out_src=0, out_tag=0, last_grant=1.
- While rst=1: req0_ready=req1_ready=0.
- Reset mid-operation discards any held result; no transfer happens on the reset edge.
- The first transfer can occur on the first edge with rst=0.
- out_* are driven from registers only. The only combinational paths are valid/out_ready → ready.

## Test plan
- Arithmetic right: req0 d=0x80000001, sa=4, right=1, arith=1, tag=3 → one cycle later out_valid=1, out_sh=0xF8000000, out_src=0, out_tag=3.
- Single requester, two operations:
  - req1 d=0x000000FF, sa=8, right=0 → out_sh=0x0000FF00, out_src=1.
  - req1 d=0x80000000, sa=31, right=1, arith=0 → out_sh=0x00000001.
- Contention: both valid continuously with out_ready=1 from reset → grants alternate 0,1,0,1. Each result appears one cycle after its grant and out_valid stays 1.
- Backpressure: out_ready=0 for 5 cycles with both requesters valid:
  - out_sh stays stable and req0_ready=req1_ready=0.
  - On out_ready=1 the next grant goes to the requester not served last.
- sa=0 passthrough: d=0x12345678, sa=0, each right/arith combination → out_sh=0x12345678.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → after the edge out_valid=0, out_sh=0, and no transfer occurs. With both requesters valid, the first post-reset grant goes to req0.
